instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 25 ++
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch_if_id_reg.sv | 22 ++
 rtl/instr_fetch.sv | 83 ++++++++
 tb/tb_instr_fetch.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its
// pipeline registers.
package instr_fetch_pkg;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] ROM_BYTES = 32'h0000_1000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Word-aligned and fully inside [base, base+bytes-4].
  function automatic logic addr_legal(input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] base,
                                      input logic [XLEN-1:0] bytes);
    return (a[1:0] == 2'b00) && (a >= base) && (a <= base + bytes - XLEN'(4));
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: hazard/redirect controls in, ROM port, IF/ID outputs.
interface instr_fetch_if #(parameter int WIDTH = 32);
  logic             stall_i;
  logic             flush_i;
  logic             redirect_i;
  logic [WIDTH-1:0] redirect_pc_i;
  logic [WIDTH-1:0] rom_addr_o;
  logic [WIDTH-1:0] rom_data_i;
  logic [WIDTH-1:0] instr_o;
  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pc_plus4_o;
  logic             valid_o;
  logic             fault_o;
  logic [WIDTH-1:0] fault_pc_o;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, rom_data_i,
    output rom_addr_o, instr_o, pc_o, pc_plus4_o, valid_o, fault_o, fault_pc_o
  );

  modport slave (
    output stall_i, flush_i, redirect_i, redirect_pc_i, rom_data_i,
    input  rom_addr_o, instr_o, pc_o, pc_plus4_o, valid_o, fault_o, fault_pc_o
  );
endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// Generic pipeline register holding an if_id_t; reset > flush > stall > load.
module instr_fetch_if_id_reg
  import instr_fetch_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   i_stall,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);
  if_id_t r_q;

  // Flush only drops the valid bit; the stale payload is masked downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i)        r_q <= '0;
    else if (i_flush) r_q.valid <= 1'b0;
    else if (!i_stall) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, next-PC mux, ROM window check, RUN/FAULT FSM
// and the IF/ID register feeding decode.
module instr_fetch #(
  parameter int               WIDTH     = instr_fetch_pkg::XLEN,
  parameter logic [WIDTH-1:0] RESET_PC  = instr_fetch_pkg::RESET_PC,
  parameter logic [WIDTH-1:0] ROM_BYTES = instr_fetch_pkg::ROM_BYTES
) (
  input logic          clk_i,
  input logic          rst_i,
  instr_fetch_if.master bus
);
  import instr_fetch_pkg::*;

  fetch_state_t     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt, w_pc_plus4, r_fault_pc;
  logic             w_nxt_legal, w_flush, w_fault_load;
  if_id_t           w_ifid_d, w_ifid_q;

  assign w_pc_plus4 = r_pc + WIDTH'(4);

  always_comb begin
    w_pc_nxt = r_pc;
    if (bus.redirect_i)                        w_pc_nxt = bus.redirect_pc_i;
    else if (r_state == RUN && !bus.stall_i)   w_pc_nxt = w_pc_plus4;
  end

  assign w_nxt_legal = addr_legal(w_pc_nxt, RESET_PC, ROM_BYTES);

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (!w_nxt_legal)                   w_state_nxt = FAULT;
      FAULT:   if (bus.redirect_i && w_nxt_legal)  w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // FSM: outputs. The ROM never sees an out-of-window address.
  always_comb begin
    bus.rom_addr_o = (r_state == FAULT) ? RESET_PC : r_pc;
    bus.fault_o    = (r_state == FAULT);
  end

  // Capture the offending address on fault entry and on each illegal
  // redirect while already faulted.
  assign w_fault_load = !w_nxt_legal && (r_state == RUN || bus.redirect_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_fault_pc <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_fault_load) r_fault_pc <= w_pc_nxt;
    end
  end

  assign bus.fault_pc_o = r_fault_pc;

  assign w_flush  = bus.flush_i || bus.redirect_i || (r_state == FAULT);
  assign w_ifid_d = '{instr: bus.rom_data_i, pc: r_pc, pc_plus4: w_pc_plus4, valid: 1'b1};

  instr_fetch_if_id_reg u_if_id (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_stall (bus.stall_i),
    .i_flush (w_flush),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign bus.instr_o    = w_ifid_q.valid ? w_ifid_q.instr : NOP_INSTR;
  assign bus.pc_o       = w_ifid_q.pc;
  assign bus.pc_plus4_o = w_ifid_q.pc_plus4;
  assign bus.valid_o    = w_ifid_q.valid;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized checks of instr_fetch against a behavioural model.
module tb_instr_fetch;
  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam logic [31:0] SIZE = 32'h0000_1000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.WIDTH(32)) bus();

  instr_fetch #(.WIDTH(32), .RESET_PC(BASE), .ROM_BYTES(SIZE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == BASE) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign bus.rom_data_i = rom_word(bus.rom_addr_o);

  function automatic bit legal(input logic [31:0] a);
    longint unsigned x, b, s;
    x = a; b = BASE; s = SIZE;
    return (x % 4 == 0) && (x >= b) && (x + 4 <= b + s);
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural PC, fault flag and IF/ID contents.
  logic [31:0] m_pc, m_fault_pc, m_instr, m_pco, m_p4, nxt;
  bit          m_fault, m_valid;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = BASE; m_fault = 0; m_fault_pc = 0;
      m_valid = 0; m_instr = 0; m_pco = 0; m_p4 = 0;
    end else if (m_fault) begin
      m_valid = 0;
      if (bus.redirect_i) begin
        m_pc = bus.redirect_pc_i;
        if (legal(m_pc)) m_fault = 0;
        else             m_fault_pc = m_pc;
      end
    end else begin
      if (bus.redirect_i)   nxt = bus.redirect_pc_i;
      else if (bus.stall_i) nxt = m_pc;
      else                  nxt = m_pc + 32'd4;
      if (bus.flush_i || bus.redirect_i) m_valid = 0;
      else if (!bus.stall_i) begin
        m_valid = 1; m_instr = rom_word(m_pc); m_pco = m_pc; m_p4 = m_pc + 32'd4;
      end
      if (!legal(nxt)) begin m_fault = 1; m_fault_pc = nxt; end
      m_pc = nxt;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rom_addr", bus.rom_addr_o, m_fault ? BASE : m_pc);
      chk("m_valid",    32'(bus.valid_o), 32'(m_valid));
      chk("m_instr",    bus.instr_o, m_valid ? m_instr : NOP);
      chk("m_fault",    32'(bus.fault_o), 32'(m_fault));
      chk("m_fault_pc", bus.fault_pc_o, m_fault_pc);
      if (m_valid) begin
        chk("m_pc_o",  bus.pc_o, m_pco);
        chk("m_pc_p4", bus.pc_plus4_o, m_p4);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rom"},   bus.rom_addr_o, BASE);
    chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_instr"}, bus.instr_o, NOP);
    chk({tag, "_pc"},    bus.pc_o, 32'd0);
    chk({tag, "_p4"},    bus.pc_plus4_o, 32'd0);
    chk({tag, "_fault"}, 32'(bus.fault_o), 32'd0);
    chk({tag, "_fpc"},   bus.fault_pc_o, 32'd0);
  endtask

  task automatic redirect_to(input logic [31:0] t);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = t;
    cyc();
    bus.redirect_i = 1'b0;
  endtask

  initial begin
    bus.stall_i = 0; bus.flush_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = 0;
    repeat (2) cyc();
    chk_en = 1;
    chk_reset("rst0");

    rst = 0;
    cyc();
    chk("first_valid", 32'(bus.valid_o), 32'd1);
    chk("first_instr", bus.instr_o, 32'h0050_0093);
    chk("first_pc",    bus.pc_o, 32'hBFC0_0000);
    chk("first_p4",    bus.pc_plus4_o, 32'hBFC0_0004);
    cyc(); chk("run_pc4", bus.pc_o, 32'hBFC0_0004);
    cyc(); chk("run_pc8", bus.pc_o, 32'hBFC0_0008);

    bus.stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", bus.pc_o, 32'hBFC0_0008);
      chk("stall_rom", bus.rom_addr_o, 32'hBFC0_000C);
    end
    bus.stall_i = 0;
    cyc(); chk("resume_pc", bus.pc_o, 32'hBFC0_000C);

    redirect_to(32'hBFC0_0100);
    chk("redir_valid", 32'(bus.valid_o), 32'd0);
    chk("redir_instr", bus.instr_o, NOP);
    chk("redir_rom",   bus.rom_addr_o, 32'hBFC0_0100);
    cyc();
    chk("redir_pc",    bus.pc_o, 32'hBFC0_0100);
    chk("redir_v2",    32'(bus.valid_o), 32'd1);

    redirect_to(32'hBFC0_0102);
    chk("mis_fault", 32'(bus.fault_o), 32'd1);
    chk("mis_fpc",   bus.fault_pc_o, 32'hBFC0_0102);
    chk("mis_valid", 32'(bus.valid_o), 32'd0);
    chk("mis_rom",   bus.rom_addr_o, BASE);
    for (int i = 0; i < 4; i++) begin
      bus.stall_i = i[0]; bus.flush_i = i[1];
      cyc();
      chk("flt_hold_fault", 32'(bus.fault_o), 32'd1);
      chk("flt_hold_valid", 32'(bus.valid_o), 32'd0);
    end
    bus.stall_i = 0; bus.flush_i = 0;
    redirect_to(BASE);
    chk("exit_fault", 32'(bus.fault_o), 32'd0);
    cyc();
    chk("exit_pc", bus.pc_o, BASE);
    chk("exit_valid", 32'(bus.valid_o), 32'd1);

    redirect_to(32'hBFC0_0FF0);
    repeat (4) cyc();
    chk("end_pc",    bus.pc_o, 32'hBFC0_0FFC);
    chk("end_valid", 32'(bus.valid_o), 32'd1);
    chk("end_fault", 32'(bus.fault_o), 32'd1);
    chk("end_fpc",   bus.fault_pc_o, 32'hBFC0_1000);
    chk("end_rom",   bus.rom_addr_o, BASE);
    cyc();
    chk("end_valid2", 32'(bus.valid_o), 32'd0);

    rst = 1; cyc(); chk_reset("rst_flt");
    rst = 0; cyc(); chk("rst_flt_pc", bus.pc_o, BASE);

    bus.stall_i = 1; cyc(); cyc();
    rst = 1; cyc(); chk_reset("rst_stall");
    rst = 0; bus.stall_i = 0; cyc();
    chk("rst_stall_pc", bus.pc_o, BASE);
    chk("rst_stall_v",  32'(bus.valid_o), 32'd1);

    for (int n = 0; n < 4000; n++) begin
      int unsigned sel;
      bus.stall_i    = ($urandom_range(0, 99) < 20);
      bus.flush_i    = ($urandom_range(0, 99) < 10);
      bus.redirect_i = ($urandom_range(0, 99) < 8);
      rst            = ($urandom_range(0, 199) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4, 5: bus.redirect_pc_i = BASE + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        6:                bus.redirect_pc_i = BASE + SIZE - 32'($urandom_range(1, 3)) * 32'd4;
        7:                bus.redirect_pc_i = BASE + 32'($urandom_range(0, 4095) & 32'hFFC) + 32'($urandom_range(1, 3));
        8:                bus.redirect_pc_i = $urandom_range(0, 1) ? BASE - 32'd4 : BASE + SIZE;
        default:          bus.redirect_pc_i = $urandom;
      endcase
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
